// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3), one input bit per clock
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_start  in   conversion request, sampled only while o_busy is low
//   i_bin    in   unsigned binary value, captured on the accepting edge
//   o_busy   out  high while a conversion is in progress
//   o_valid  out  one-cycle pulse when o_bcd/o_ovf have just been updated
//   o_bcd    out  packed BCD, ones digit in [3:0], held between conversions
//   o_ovf    out  last captured value exceeded 10^DIGITS-1, held with o_bcd
module bin2bcd_seq #(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf
);
    localparam int BCD_W = 4*DIGITS;
    localparam int ACC_W = BCD_W+1;
    localparam int CNT_W = $clog2(BIN_W+1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r*64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS)-64'd1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             r_state;
    logic [BIN_W-1:0]   r_sh;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_cap;
    logic               r_busy;
    logic               r_valid;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_ovf;

    logic [BCD_W-1:0]   w_adj;
    logic [ACC_W-1:0]   w_acc_nx;
    logic               w_ovf;

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign w_adj[4*d+:4] = (r_acc[4*d+:4] >= 4'd5) ? r_acc[4*d+:4]+4'd3 : r_acc[4*d+:4];
    end

    // Top accumulator bit is a sticky carry: once a digit overflows out of the
    // BCD field it stays set, forcing saturation even if ovf_cap were clear.
    assign w_acc_nx = {r_acc[ACC_W-1] | w_adj[BCD_W-1], w_adj[BCD_W-2:0], r_sh[BIN_W-1]};
    assign w_ovf    = 64'(i_bin) > MAX_VAL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sh      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_cap <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (i_start) begin
                    r_sh      <= i_bin;
                    r_acc     <= '0;
                    r_cnt     <= CNT_W'(BIN_W);
                    r_ovf_cap <= w_ovf;
                    r_busy    <= 1'b1;
                    r_state   <= SHIFT;
                end
            end else begin
                r_acc <= w_acc_nx;
                r_sh  <= {r_sh[BIN_W-2:0], 1'b0};
                r_cnt <= r_cnt-1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b1;
                    r_bcd   <= (r_ovf_cap || w_acc_nx[ACC_W-1]) ? {DIGITS{4'h9}} : w_acc_nx[BCD_W-1:0];
                    r_ovf   <= r_ovf_cap;
                end
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_valid = r_valid;
    assign o_bcd   = r_bcd;
    assign o_ovf   = r_ovf;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq (4-digit and 3-digit instances)
module tb_bin2bcd_seq;
    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start4 = 1'b0, start3 = 1'b0;
    logic [12:0] bin4 = '0, bin3 = '0;
    logic        busy4, valid4, ovf4, busy3, valid3, ovf3;
    logic [15:0] bcd4;
    logic [11:0] bcd3;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q4[$], q3[$];
    exp_t e4, e3;

    bin2bcd_seq #(.BIN_W(13), .DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_start(start4), .i_bin(bin4),
        .o_busy(busy4), .o_valid(valid4), .o_bcd(bcd4), .o_ovf(ovf4)
    );

    bin2bcd_seq #(.BIN_W(13), .DIGITS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_start(start3), .i_bin(bin3),
        .o_busy(busy3), .o_valid(valid3), .o_bcd(bcd3), .o_ovf(ovf3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc+1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (valid4) begin
            if (q4.size() == 0) chk("unexpected_valid4", 32'd1, 32'd0);
            else begin
                e4 = q4.pop_front();
                chk("bcd4", 32'(bcd4), 32'(e4.bcd));
                chk("ovf4", 32'(ovf4), 32'(e4.ovf));
                chk("latency4", cyc, e4.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (valid3) begin
            if (q3.size() == 0) chk("unexpected_valid3", 32'd1, 32'd0);
            else begin
                e3 = q3.pop_front();
                chk("bcd3", 32'(bcd3), 32'(e3.bcd));
                chk("ovf3", 32'(ovf3), 32'(e3.ovf));
                chk("latency3", cyc, e3.cyc);
            end
        end
    end

    // One isolated conversion: accept edge is the next posedge, result is due
    // 13 edges later; also checks busy width and that the result is held.
    task automatic conv(input bit d3, input logic [12:0] v, input logic [15:0] eb, input bit eo);
        int nb;
        @(negedge clk);
        if (d3) begin
            start3 = 1'b1; bin3 = v;
            q3.push_back('{bcd: eb, ovf: eo, cyc: cyc+14});
        end else begin
            start4 = 1'b1; bin4 = v;
            q4.push_back('{bcd: eb, ovf: eo, cyc: cyc+14});
        end
        @(negedge clk);
        start3 = 1'b0; start4 = 1'b0;
        bin3 = ~v; bin4 = ~v;
        nb = 0;
        while ((d3 ? busy3 : busy4) && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        chk(d3 ? "busy_len3" : "busy_len4", nb, 13);
        repeat (3) @(negedge clk);
        #1;
        chk("result_pending", d3 ? q3.size() : q4.size(), 0);
        chk("hold_bcd", d3 ? {20'h0, bcd3} : {16'h0, bcd4}, {16'h0, eb});
    endtask

    initial begin
        int c;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_valid", 32'(valid4), 32'd0);
        chk("rst_bcd", 32'(bcd4), 32'd0);
        chk("rst_ovf", 32'(ovf4), 32'd0);
        chk("rst_bcd3", 32'(bcd3), 32'd0);

        conv(0, 13'd0,    16'h0000, 0);
        conv(0, 13'd1234, 16'h1234, 0);
        conv(0, 13'd8191, 16'h8191, 0);
        conv(0, 13'd9,    16'h0009, 0);
        conv(0, 13'd5,    16'h0005, 0);
        conv(0, 13'd4,    16'h0004, 0);
        conv(0, 13'd5959, 16'h5959, 0);

        // start held high: second accept is in the o_valid cycle, bin changes mid-run ignored
        @(negedge clk);
        c = cyc;
        start4 = 1'b1; bin4 = 13'd4095;
        q4.push_back('{bcd: 16'h4095, ovf: 1'b0, cyc: c+14});
        q4.push_back('{bcd: 16'h0007, ovf: 1'b0, cyc: c+28});
        repeat (3) @(negedge clk);
        bin4 = 13'd7;
        repeat (12) @(negedge clk);
        start4 = 1'b0; bin4 = 13'h1FFF;
        for (int i = 0; i < 40 && q4.size() != 0; i++) @(negedge clk);
        #1;
        chk("held_start_pending", q4.size(), 0);
        repeat (16) @(negedge clk);

        // reset mid-conversion: outputs clear at once and no result is produced
        start4 = 1'b1; bin4 = 13'd5555;
        @(negedge clk);
        start4 = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy4), 32'd0);
        chk("arst_valid", 32'(valid4), 32'd0);
        chk("arst_bcd", 32'(bcd4), 32'd0);
        chk("arst_ovf", 32'(ovf4), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        conv(0, 13'd42, 16'h0042, 0);

        conv(1, 13'd1000, 16'h0999, 1);
        conv(1, 13'd999,  16'h0999, 0);
        conv(1, 13'd8191, 16'h0999, 1);
        conv(1, 13'd507,  16'h0507, 0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
